// File: rtl/led_seq_if.sv
// Control/status bundle between the board top level and the LED pattern
// sequencer: button pulses and mode select in, LED drive and status out.
interface led_seq_if #(
   parameter int WIDTH = 12
);
   logic             start;
   logic             stop;
   logic [1:0]       mode;
   logic [WIDTH-1:0] led;
   logic             busy;
   logic             step;

   modport master (
      output start, stop, mode,
      input  led, busy, step
   );

   modport slave (
      input  start, stop, mode,
      output led, busy, step
   );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaled rotate/bounce/count/blink patterns on an
// active-low LED bank, with idle/run/pause control from button pulses.
module led_seq_ctrl #(
   parameter int WIDTH = 12,
   parameter int DIV   = 25_000_000
) (
   input logic   clk,
   input logic   rst_n,
   led_seq_if.slave bus
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TOP = ONE << (WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] pat_nx, pat_init;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d, dir_nx;
   logic [1:0]       mode_q, mode_d;
   logic             step_q, step_d;
   logic             tick;

   assign tick = (state_q == RUN) && (cnt_q == LAST);

   always_comb begin
      pat_init = ONE;
      unique case (bus.mode)
         2'd0:    pat_init = ONE;
         2'd1:    pat_init = ONE;
         2'd2:    pat_init = '0;
         default: pat_init = '1;
      endcase
   end

   // dir: 0 = shifting toward the MSB, 1 = toward the LSB
   always_comb begin
      pat_nx = pat_q;
      dir_nx = dir_q;
      unique case (mode_q)
         2'd0: pat_nx = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
         2'd1: begin
            pat_nx = dir_q ? (pat_q >> 1) : (pat_q << 1);
            if (pat_nx == TOP) begin
               dir_nx = 1'b1;
            end else if (pat_nx == ONE) begin
               dir_nx = 1'b0;
            end
         end
         2'd2:    pat_nx = pat_q + ONE;
         default: pat_nx = ~pat_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      step_d  = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
         pat_d   = '0;
         cnt_d   = '0;
         dir_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = RUN;
                  mode_d  = bus.mode;
                  cnt_d   = '0;
                  pat_d   = pat_init;
                  dir_d   = 1'b0;
               end
            end
            RUN: begin
               if (bus.start) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  cnt_d  = '0;
                  pat_d  = pat_nx;
                  dir_d  = dir_nx;
                  step_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PAUSE: begin
               if (bus.start) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
               pat_d   = '0;
               cnt_d   = '0;
               dir_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'd0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
      end
   end

   assign bus.led  = ~pat_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.step = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random button traffic,
// compared cycle by cycle against a step-count based pattern model.
module tb_led_seq_ctrl;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   led_seq_if #(.WIDTH(12)) bus ();

   led_seq_ctrl #(
      .WIDTH(12),
      .DIV  (DIV)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // model: run/pause flags, latched mode, run cycles and completed steps
   bit m_busy, m_run, m_step;
   int m_mode, m_rc, m_k;

   function automatic logic [11:0] m_pat();
      int p;
      case (m_mode)
         0: return 12'(1) << (m_k % 12);
         1: begin
            p = m_k % 22;
            return 12'(1) << ((p <= 11) ? p : 22 - p);
         end
         2: return 12'(m_k % 4096);
         default: return (m_k % 2 == 0) ? 12'hFFF : 12'h000;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic m_reset();
      m_busy = 0;
      m_run  = 0;
      m_step = 0;
      m_rc   = 0;
      m_k    = 0;
      m_mode = 0;
   endtask

   task automatic m_clock(bit st, bit sp, int md);
      m_step = 0;
      if (!rst_n) begin
         m_reset();
      end else if (sp) begin
         m_busy = 0;
         m_run  = 0;
         m_rc   = 0;
         m_k    = 0;
      end else if (!m_busy) begin
         if (st) begin
            m_busy = 1;
            m_run  = 1;
            m_mode = md;
            m_rc   = 0;
            m_k    = 0;
         end
      end else if (st) begin
         m_run = !m_run;
      end else if (m_run) begin
         m_rc++;
         if (m_rc == DIV) begin
            m_rc   = 0;
            m_k++;
            m_step = 1;
         end
      end
   endtask

   task automatic compare(string tag);
      logic [11:0] want;
      want = m_busy ? ~m_pat() : 12'hFFF;
      check({tag, ".led"}, 32'(bus.led), 32'(want));
      check({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
      check({tag, ".step"}, 32'(bus.step), 32'(m_step));
   endtask

   task automatic cyc(bit st, bit sp, logic [1:0] md, string tag);
      @(negedge clk);
      bus.start = st;
      bus.stop  = sp;
      bus.mode  = md;
      @(posedge clk);
      m_clock(st, sp, int'(md));
      #1;
      compare(tag);
   endtask

   task automatic idle(int n, string tag);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 2'($urandom_range(3)), tag);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 2'd0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      compare("por");
      @(negedge clk);
      rst_n = 1'b1;
      idle(3, "idle");

      // reset asserted mid-run, checked immediately and while held
      cyc(1'b1, 1'b0, 2'd0, "rst_run");
      idle(6, "rst_run");
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      compare("rst_async");
      idle(2, "rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      idle(20, "rst_idle");

      cyc(1'b1, 1'b0, 2'd0, "rot");
      idle(13 * DIV + 2, "rot");
      cyc(1'b0, 1'b1, 2'd0, "rot_stop");

      cyc(1'b1, 1'b0, 2'd1, "bounce");
      idle(24 * DIV + 2, "bounce");
      cyc(1'b0, 1'b1, 2'd0, "bounce_stop");

      cyc(1'b1, 1'b0, 2'd2, "count");
      idle(4096 * DIV + 3 * DIV, "count");
      cyc(1'b0, 1'b1, 2'd0, "count_stop");

      cyc(1'b1, 1'b0, 2'd3, "blink");
      idle(6 * DIV, "blink");
      cyc(1'b0, 1'b1, 2'd0, "blink_stop");

      // pause while the prescaler holds 2, resume 10 cycles later
      cyc(1'b1, 1'b0, 2'd0, "pause");
      idle(2, "pause");
      cyc(1'b1, 1'b0, 2'd0, "pause_in");
      idle(10, "pause_hold");
      cyc(1'b1, 1'b0, 2'd0, "resume");
      idle(1, "resume");
      cyc(1'b0, 1'b0, 2'd0, "resume_step");
      check("resume_step_pulse", 32'(bus.step), 32'd1);
      idle(2 * DIV, "resume");

      cyc(1'b1, 1'b1, 2'd0, "both");
      idle(2, "both");

      // stop coincident with the first tick
      cyc(1'b1, 1'b0, 2'd1, "stop_tick");
      idle(DIV - 1, "stop_tick");
      cyc(1'b0, 1'b1, 2'd0, "stop_tick");
      check("stop_tick_led", 32'(bus.led), 32'hFFF);
      idle(DIV + 1, "stop_tick");

      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(11) == 0), ($urandom_range(59) == 0),
             2'($urandom_range(3)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer for the board's 12 active-low LEDs. Owns a prescaler and a small run/pause/idle state machine. On each prescaler tick it advances one of four display patterns: rotate, bounce, binary count, or all-blink. It sits directly under the top level, with start/stop driven by already-synchronized button pulses, and replaces the single free-running blinker on the LED bank.

## Interface

Parameters:
- `WIDTH`, 12, number of LEDs driven. Fixed at 12 for the patterns below; other values need not be supported.
- `DIV`, 25_000_000, clock cycles per pattern step (0.5 s at 50 MHz). Must be ≥ 2; benches override it with a small value.

Ports:
- `clk`  input  1  system clock, 50 MHz on board.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse, synchronous to `clk`. Starts from IDLE and toggles RUN/PAUSE.
- `stop`  input  1  single-cycle pulse, synchronous to `clk`. Returns to IDLE from any state.
- `mode`  input  2  pattern select; sampled only on the IDLE→RUN transition.
- `led`  output  12  LED drive, active low (1 = off).
- `busy`  output  1  high whenever state ≠ IDLE.
- `step`  output  1  one-cycle pulse, high in the first cycle a new pattern value is visible.

## Operation

Registers:
- State: IDLE, RUN, PAUSE.
- `pat[11:0]`: current pattern.
- `cnt`: prescaler, $clog2(DIV) bits.
- `dir`: bounce direction.
- `mode_q`: latched mode.

Reset values (async, rst_n=0): state=IDLE, pat=0, cnt=0, dir=left, mode_q=0, step=0. Resulting outputs: `led`=12'hFFF, `busy`=0, `step`=0.

Outputs:
- `led` = ~pat. It is driven from the register directly, with no combinational path from the inputs.
- `pat` is 0 in IDLE, so all LEDs are off in IDLE.

Transitions. Priority is `stop` over `start`; both asserted in the same cycle acts as `stop`.
- IDLE + start: go to RUN. mode_q ← mode, cnt ← 0, pat ← initial value for mode, dir ← left.
- RUN + start: go to PAUSE. cnt and pat hold.
- PAUSE + start: go to RUN. cnt resumes from its held value, so no time is lost or gained.
- Any state + stop: go to IDLE. pat ← 0, cnt ← 0, dir ← left. Any tick in the same cycle is discarded: no pattern update and no `step`.

Prescaler:
- Counts only in RUN.
- tick = (state==RUN && cnt==DIV-1). On tick, cnt wraps to 0; otherwise it increments.
- In PAUSE, cnt holds. In IDLE, cnt stays 0.

Patterns. Each line gives the initial value, then the action on each tick.
- mode 0, rotate: initial 12'h001. Rotate left one place; 12'h800 → 12'h001.
- mode 1, bounce:
  - Initial 12'h001, dir=left.
  - Shift one place in direction `dir`.
  - Direction flips when the new value is 12'h800 (set dir=right) or 12'h001 (set dir=left).
  - Sequence: 001, 002, …, 800, 400, …, 001, 002; period 22 steps.
- mode 2, count: initial 12'h000. Add 1 modulo 4096; 12'hFFF → 12'h000.
- mode 3, blink: initial 12'hFFF. Bitwise invert on each tick (FFF ↔ 000).

Changes on `mode` while in RUN or PAUSE are ignored until the next IDLE→RUN transition.

`start` and `stop` are level-sampled each cycle. A pulse wider than one cycle is treated as repeated pulses. Callers are required to supply single-cycle pulses.

## Timing

- start accepted in cycle N (from IDLE): `busy`=1 and the initial `pat`/`led` are visible from N+1.
- First tick occurs in cycle N+DIV. The new pattern and `step`=1 are visible in N+DIV+1.
- Subsequent steps follow every DIV cycles while in RUN.
- stop in cycle N: from N+1, `led`=12'hFFF, `busy`=0, `step`=0.
- PAUSE→RUN resumption: if cnt held value k, the next tick falls DIV-1-k cycles after the resume cycle.
- Latency from tick to `led` is exactly 1 cycle. `step` is coincident with the first cycle of the new `led` value.

## Test plan

All scenarios use DIV=4.

1. Reset, then idle.
   - Stimulus: assert rst_n=0 mid-run, release, wait 20 cycles.
   - Required: `led`=FFF, `busy`=0, `step`=0 throughout.
2. Rotate.
   - Stimulus: mode=0, start at cycle N.
   - Required:
     - `led`=FFE at N+1.
     - `step` pulses at N+5, N+9, ….
     - `led` sequence FFE, FFD, FFB, …, 7FF, then FFE after 12 steps.
3. Bounce.
   - Stimulus: mode=1, start, run 24 steps.
   - Required:
     - `pat` goes 001 → 800 in 11 steps, back to 001 at step 22, and 002 at step 23.
     - No value repeats at the ends.
4. Count and blink.
   - Stimulus: mode=2, run to pat=FFF.
   - Required: pat wraps to 000 on the next step.
   - Stimulus: separately, mode=3.
   - Required: `led` alternates 000/FFF on each step.
5. Pause/resume.
   - Stimulus: in RUN, give start when cnt=2; hold 10 cycles; give start again.
   - Required:
     - No `step` during the pause.
     - `pat` unchanged during the pause.
     - Next `step` exactly 2 cycles after the resume cycle (cnt held at 2, so DIV-1-k = 1 cycle to the tick, plus 1 cycle latency).
6. Collisions.
   - start+stop in the same cycle from RUN → IDLE.
   - stop in the tick cycle → no `step`, `led`=FFF next cycle.
   - `mode` changed during RUN → pattern unaffected until restart from IDLE.
